// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word definitions and loader FSM types.
package cpu_ctrl_pkg;

  localparam int unsigned CTRL_W = 15;

  // Control-word bit positions
  localparam int unsigned BIT_CP   = 14;
  localparam int unsigned BIT_EP   = 13;
  localparam int unsigned BIT_LP   = 12;
  localparam int unsigned BIT_NLMA = 11;
  localparam int unsigned BIT_NLMD = 10;
  localparam int unsigned BIT_NCE  = 9;
  localparam int unsigned BIT_NLR  = 8;
  localparam int unsigned BIT_NLI  = 7;
  localparam int unsigned BIT_NEI  = 6;
  localparam int unsigned BIT_NLA  = 5;
  localparam int unsigned BIT_EA   = 4;
  localparam int unsigned BIT_SUB  = 3;
  localparam int unsigned BIT_EU   = 2;
  localparam int unsigned BIT_NLB  = 1;
  localparam int unsigned BIT_NLO  = 0;

  typedef logic [CTRL_W-1:0] ctrl_word_t;

  // Every strobe at its inactive level
  localparam ctrl_word_t CTRL_IDLE = 15'h0FE3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_NEXT,
    S_DONE
  } loader_state_t;

  // Registered per-state output decode
  typedef struct packed {
    logic       data_ready;
    logic       cpu_hold;
    logic       bus_oe;
    logic       ram_we_n;
    logic       load_done;
    ctrl_word_t ctrl;
  } loader_out_t;

  // Output values that hold while the FSM sits in state s
  function automatic loader_out_t decode_outputs(loader_state_t s);
    loader_out_t o;
    o.data_ready = 1'b0;
    o.cpu_hold   = (s != S_IDLE);
    o.bus_oe     = 1'b0;
    o.ram_we_n   = 1'b1;
    o.load_done  = 1'b0;
    o.ctrl       = CTRL_IDLE;
    case (s)
      S_WAIT_BYTE: o.data_ready = 1'b1;
      S_ADDR: begin
        o.bus_oe         = 1'b1;
        o.ctrl[BIT_NLMA] = 1'b0;
      end
      S_DATA: begin
        o.bus_oe         = 1'b1;
        o.ctrl[BIT_NLMD] = 1'b0;
      end
      S_WRITE: begin
        o.ram_we_n      = 1'b0;
        o.ctrl[BIT_NCE] = 1'b0;
      end
      S_DONE:  o.load_done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ram_loader.sv
// Bus-owning sequencer that fills program RAM from external pins while the CPU is held.
module ram_loader
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  input  logic [CTRL_W-1:0] cpu_ctrl,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              cpu_hold,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              ram_we_n,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  loader_state_t     state;
  loader_out_t       outs;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] byte_reg;
  logic              last_reg;

  // FSM, address/count tracking and registered output decode of the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      outs       <= decode_outputs(S_IDLE);
      addr       <= '0;
      count      <= '0;
      load_count <= '0;
      byte_reg   <= '0;
      last_reg   <= 1'b0;
      bus_out    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr  <= '0;
            count <= '0;
            state <= S_WAIT_BYTE;
            outs  <= decode_outputs(S_WAIT_BYTE);
          end
        end
        S_WAIT_BYTE: begin
          if (data_valid) begin
            byte_reg <= data_in;
            last_reg <= data_last;
            bus_out  <= DATA_W'(addr);
            state    <= S_ADDR;
            outs     <= decode_outputs(S_ADDR);
          end
        end
        S_ADDR: begin
          bus_out <= byte_reg;
          state   <= S_DATA;
          outs    <= decode_outputs(S_DATA);
        end
        S_DATA: begin
          bus_out <= '0;
          state   <= S_WRITE;
          outs    <= decode_outputs(S_WRITE);
        end
        S_WRITE: begin
          state <= S_NEXT;
          outs  <= decode_outputs(S_NEXT);
        end
        S_NEXT: begin
          count <= count + CNT_W'(1);
          // Address never wraps: the top address always ends the load
          if (last_reg || (&addr)) begin
            load_count <= count + CNT_W'(1);
            state      <= S_DONE;
            outs       <= decode_outputs(S_DONE);
          end else begin
            addr  <= addr + ADDR_W'(1);
            state <= S_WAIT_BYTE;
            outs  <= decode_outputs(S_WAIT_BYTE);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          outs  <= decode_outputs(S_IDLE);
        end
        default: begin
          state <= S_IDLE;
          outs  <= decode_outputs(S_IDLE);
        end
      endcase
    end
  end

  // CPU control passes straight through only while idle
  always_comb begin
    ctrl_out = outs.ctrl;
    if (state == S_IDLE) ctrl_out = cpu_ctrl;
  end

  assign data_ready = outs.data_ready;
  assign cpu_hold   = outs.cpu_hold;
  assign bus_oe     = outs.bus_oe;
  assign ram_we_n   = outs.ram_we_n;
  assign load_done  = outs.load_done;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a small MAR/MDR/RAM datapath model.
module tb_ram_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_last;
  logic        data_ready;
  logic [14:0] cpu_ctrl;
  logic [14:0] ctrl_out;
  logic        cpu_hold;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        ram_we_n;
  logic        load_done;
  logic [4:0]  load_count;

  int tests = 0;
  int fails = 0;

  // Datapath model state
  logic [3:0] mar;
  logic [7:0] mdr;
  logic [7:0] ram [16];
  int wr_cnt = 0;
  int wr0_cnt = 0;
  int done_cnt = 0;
  int strobe_cnt = 0;

  ram_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_ready (data_ready),
    .cpu_ctrl   (cpu_ctrl),
    .ctrl_out   (ctrl_out),
    .cpu_hold   (cpu_hold),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .ram_we_n   (ram_we_n),
    .load_done  (load_done),
    .load_count (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAR/MDR/RAM model sampled mid-cycle, plus event counters
  always @(negedge clk) begin
    if (!rst) begin
      if (ctrl_out[11] == 1'b0) mar = bus_out[3:0];
      if (ctrl_out[10] == 1'b0) mdr = bus_out;
      if (ram_we_n == 1'b0) begin
        ram[mar] = mdr;
        wr_cnt++;
        if (mar == 4'd0) wr0_cnt++;
      end
      if (load_done) done_cnt++;
      if (ctrl_out[11:9] != 3'b111 || ram_we_n == 1'b0) strobe_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (data_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", 32'(data_ready), 32'd1);
  endtask

  // Offer one byte and follow it through ADDR, DATA, WRITE and NEXT
  task automatic send_byte(input logic [7:0] b, input logic last, input logic [3:0] exp_addr);
    wait_ready();
    data_in    = b;
    data_last  = last;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    data_last  = 1'b0;
    chk("addr_bus", 32'(bus_out), 32'(exp_addr));
    chk("addr_oe", 32'(bus_oe), 32'd1);
    chk("addr_ctrl", 32'(ctrl_out), 32'h07E3);
    step();
    chk("data_bus", 32'(bus_out), 32'(b));
    chk("data_ctrl", 32'(ctrl_out), 32'h0BE3);
    step();
    chk("write_we", 32'(ram_we_n), 32'd0);
    chk("write_oe", 32'(bus_oe), 32'd0);
    chk("write_ctrl", 32'(ctrl_out), 32'h0DE3);
    step();
    chk("next_we", 32'(ram_we_n), 32'd1);
    chk("next_ctrl", 32'(ctrl_out), 32'h0FE3);
  endtask

  initial begin
    int s0;
    rst        = 1'b1;
    start      = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    data_last  = 1'b0;
    cpu_ctrl   = 15'h1234;
    mar        = 4'd0;
    mdr        = 8'h00;
    for (int i = 0; i < 16; i++) ram[i] = 8'hFF;

    // Reset state
    #3;
    chk("rst_ctrl", 32'(ctrl_out), 32'h1234);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_we", 32'(ram_we_n), 32'd1);
    chk("rst_oe", 32'(bus_oe), 32'd0);
    chk("rst_ready", 32'(data_ready), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_bus", 32'(bus_out), 32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Three-byte load
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ready", 32'(data_ready), 32'd1);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    chk("start_ctrl", 32'(ctrl_out), 32'h0FE3);
    send_byte(8'hA1, 1'b0, 4'd0);
    send_byte(8'hB2, 1'b0, 4'd1);
    send_byte(8'hC3, 1'b1, 4'd2);
    step();
    chk("l3_done", 32'(load_done), 32'd1);
    chk("l3_count", 32'(load_count), 32'd3);
    chk("l3_done_hold", 32'(cpu_hold), 32'd1);
    step();
    chk("l3_idle_done", 32'(load_done), 32'd0);
    chk("l3_idle_hold", 32'(cpu_hold), 32'd0);
    chk("l3_idle_ctrl", 32'(ctrl_out), 32'h1234);
    chk("l3_count_hold", 32'(load_count), 32'd3);
    chk("l3_writes", 32'(wr_cnt), 32'd3);
    chk("l3_done_cnt", 32'(done_cnt), 32'd1);
    chk("l3_ram0", 32'(ram[0]), 32'hA1);
    chk("l3_ram1", 32'(ram[1]), 32'hB2);
    chk("l3_ram2", 32'(ram[2]), 32'hC3);

    // Full 16-byte load without data_last
    wr_cnt  = 0;
    wr0_cnt = 0;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 4'(i));
    step();
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_count", 32'(load_count), 32'd16);
    step();
    chk("full_idle_hold", 32'(cpu_hold), 32'd0);
    chk("full_writes", 32'(wr_cnt), 32'd16);
    chk("full_addr0_writes", 32'(wr0_cnt), 32'd1);
    chk("full_ram0", 32'(ram[0]), 32'h00);
    chk("full_ram15", 32'(ram[15]), 32'h0F);
    chk("full_done_cnt", 32'(done_cnt), 32'd2);

    // Stalled source, then spurious start and data_valid
    start = 1'b1;
    step();
    start = 1'b0;
    s0 = strobe_cnt;
    for (int i = 0; i < 7; i++) step();
    chk("stall_hold", 32'(cpu_hold), 32'd1);
    chk("stall_ctrl", 32'(ctrl_out), 32'h0FE3);
    chk("stall_ready", 32'(data_ready), 32'd1);
    chk("stall_strobes", 32'(strobe_cnt - s0), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("spur_start_ready", 32'(data_ready), 32'd1);
    chk("spur_start_oe", 32'(bus_oe), 32'd0);
    data_in    = 8'h55;
    data_valid = 1'b1;
    step();
    chk("spur_addr_bus", 32'(bus_out), 32'd0);
    data_in = 8'hEE;
    step();
    data_valid = 1'b0;
    chk("spur_valid_data", 32'(bus_out), 32'h55);
    chk("spur_valid_ctrl", 32'(ctrl_out), 32'h0BE3);
    step();
    step();
    send_byte(8'h66, 1'b1, 4'd1);
    step();
    chk("spur_done", 32'(load_done), 32'd1);
    chk("spur_count", 32'(load_count), 32'd2);
    step();
    chk("spur_ram0", 32'(ram[0]), 32'h55);
    chk("spur_ram1", 32'(ram[1]), 32'h66);

    // Reset during DATA of the second byte
    cpu_ctrl = 15'h2A5C;
    start    = 1'b1;
    step();
    start = 1'b0;
    send_byte(8'h11, 1'b0, 4'd0);
    wait_ready();
    data_in    = 8'h22;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    step();
    chk("mid_pre_oe", 32'(bus_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_oe", 32'(bus_oe), 32'd0);
    chk("mid_we", 32'(ram_we_n), 32'd1);
    chk("mid_hold", 32'(cpu_hold), 32'd0);
    chk("mid_ctrl", 32'(ctrl_out), 32'h2A5C);
    chk("mid_ready", 32'(data_ready), 32'd0);
    chk("mid_count", 32'(load_count), 32'd0);
    step();
    rst = 1'b0;
    step();
    wr_cnt = 0;
    start  = 1'b1;
    step();
    start = 1'b0;
    send_byte(8'h77, 1'b1, 4'd0);
    step();
    chk("post_done", 32'(load_done), 32'd1);
    chk("post_count", 32'(load_count), 32'd1);
    step();
    chk("post_ram0", 32'(ram[0]), 32'h77);
    chk("post_writes", 32'(wr_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
